// File: rtl/klotski_grid_vga_gen.sv
// klotski_grid_vga_gen: SVGA timing generator painting a 4x4 tile grid from a double-buffered colour table.
`timescale 1ns/1ps
module klotski_grid_vga_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter int   TILE_W   = 200,
    parameter int   TILE_H   = 150,
    parameter int   BORDER   = 2,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_wr_valid,
    input  logic [3:0]  i_wr_idx,
    input  logic [23:0] i_wr_color,
    input  logic        i_commit,
    output logic        o_commit_pending,
    output logic [12:0] o_H_Counter,
    output logic [12:0] o_V_Counter,
    output logic [7:0]  o_Red,
    output logic [7:0]  o_Green,
    output logic [7:0]  o_Blue,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank,
    output logic        o_frame_start
);
    localparam logic [12:0] HA  = 13'(H_ACTIVE);
    localparam logic [12:0] HT  = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [12:0] HS0 = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS1 = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VA  = 13'(V_ACTIVE);
    localparam logic [12:0] VT  = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [12:0] VS0 = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS1 = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0]  TW  = 8'(TILE_W - 1);
    localparam logic [7:0]  TH  = 8'(TILE_H - 1);
    localparam logic [7:0]  BD  = 8'(BORDER);

    // h/v and the trackers describe the position presented at the next enabled edge
    logic [12:0] h, v;
    logic [7:0]  px, ln;
    logic [1:0]  tx, ty;
    logic [23:0] act [16];
    logic [23:0] pend [16];
    logic        wrap_h, wrap_v, swap, in_act;
    logic [23:0] color, pix;

    always_comb begin
        wrap_h = h == HT - 13'd1;
        wrap_v = v == VT - 13'd1;
        swap   = i_enable && h == 13'd0 && v == 13'd0 && o_commit_pending;
        in_act = h < HA && v < VA;
        // the swap edge already paints from the table being committed
        color  = swap ? pend[{ty, tx}] : act[{ty, tx}];
        pix    = (in_act && px >= BD && ln >= BD) ? color : 24'd0;
    end

    always_ff @(posedge i_Clk or posedge i_rst) begin
        if (i_rst) begin
            h <= '0;
            v <= '0;
            px <= '0;
            ln <= '0;
            tx <= '0;
            ty <= '0;
            for (int i = 0; i < 16; i++) begin
                act[i] <= '0;
                pend[i] <= '0;
            end
            o_commit_pending <= 1'b0;
            o_H_Counter <= '0;
            o_V_Counter <= '0;
            {o_Red, o_Green, o_Blue} <= '0;
            o_hsync <= ~SYNC_POL;
            o_vsync <= ~SYNC_POL;
            o_blank <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            if (i_wr_valid) pend[i_wr_idx] <= i_wr_color;
            if (swap) act <= pend;
            o_commit_pending <= i_commit | (o_commit_pending & ~swap);
            if (i_enable) begin
                o_H_Counter <= h;
                o_V_Counter <= v;
                {o_Red, o_Green, o_Blue} <= pix;
                o_hsync <= (h >= HS0 && h < HS1) ? SYNC_POL : ~SYNC_POL;
                o_vsync <= (v >= VS0 && v < VS1) ? SYNC_POL : ~SYNC_POL;
                o_blank <= ~in_act;
                o_frame_start <= h == 13'd0 && v == 13'd0;
                h <= wrap_h ? 13'd0 : h + 13'd1;
                px <= (wrap_h || px == TW) ? 8'd0 : px + 8'd1;
                tx <= wrap_h ? 2'd0 : (px == TW ? tx + 2'd1 : tx);
                if (wrap_h) begin
                    v <= wrap_v ? 13'd0 : v + 13'd1;
                    ln <= (wrap_v || ln == TH) ? 8'd0 : ln + 8'd1;
                    ty <= wrap_v ? 2'd0 : (ln == TH ? ty + 2'd1 : ty);
                end
            end else begin
                {o_Red, o_Green, o_Blue} <= '0;
                o_blank <= 1'b1;
                o_frame_start <= 1'b0;
            end
        end
    end
endmodule
